// File: rtl/seg_stream_reader.sv
// rtl/seg_stream_reader.sv - segment read initiator streaming a contiguous address range (option: SEG_STREAM_CHECKSUM_EN)
module seg_stream_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 100,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              accept;
    logic              fetch;
    logic              cmd_take;

    // A beat leaves when the downstream takes it; a new word is read whenever
    // words remain and the output register is empty or being emptied.
    assign accept   = m_valid & m_ready;
    assign fetch    = (state == S_RUN) && (remaining != '0) && (!m_valid || m_ready);
    assign cmd_take = (state == S_IDLE) && start;
    assign mem_a    = addr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: zero-length commands skip straight to the done pulse
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept && m_last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Address walker and output register; the address wraps at the segment end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
        end else if (cmd_take && (length != '0)) begin
            addr      <= base_addr;
            remaining <= length;
        end else if (fetch) begin
            m_data    <= mem_rd;
            m_valid   <= 1'b1;
            m_last    <= (remaining == LEN_W'(1));
            remaining <= remaining - LEN_W'(1);
            addr      <= (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
        end else if (accept) begin
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
        end
    end

`ifdef SEG_STREAM_CHECKSUM_EN
    logic [15:0] csum;

    // Running sum of accepted beats, cleared by each accepted command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 16'd0;
        end else if (cmd_take) begin
            csum <= 16'd0;
        end else if (accept) begin
            csum <= csum + 16'(m_data);
        end
    end

    assign checksum = csum;
`else
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_seg_stream_reader.sv
// tb/tb_seg_stream_reader.sv - scoreboard bench for seg_stream_reader
module tb_seg_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  length;
    logic        busy;
    logic        done;
    logic [9:0]  mem_a;
    logic [7:0]  mem_rd;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready;
    logic [15:0] checksum;

    logic [7:0]  mem [0:99];
    logic [8:0]  sb [$];
    int          checks;
    int          failures;
    int          cyc;
    int          t0;
    logic [7:0]  hold_d;
    logic [9:0]  hold_a;
    logic [15:0] exp_csum;

    seg_stream_reader #(
        .DATA_W(8), .ADDR_W(10), .DEPTH(100), .LEN_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .mem_a(mem_a),
        .mem_rd(mem_rd), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_ready(m_ready), .checksum(checksum)
    );

    assign mem_rd = (mem_a < 10'd100) ? mem[mem_a] : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every beat the DUT hands over must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_beat actual=0x%0h required=none at cycle %0d", m_data, cyc);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                chk("beat_data", 32'(m_data), 32'(e[7:0]));
                chk("beat_last", 32'(m_last), 32'(e[8]));
            end
        end
    end

    task automatic do_start(input logic [9:0] b, input logic [9:0] l);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        length = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string name, input int exp_edges);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(cyc - t0), 32'(exp_edges));
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; t0 = 0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
        for (int i = 0; i < 100; i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_mem_a", 32'(mem_a), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        rst_n = 1'b1;

        // Basic 4-word stream from address 0
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        sb.push_back({1'b0, 8'h11}); sb.push_back({1'b0, 8'h22});
        sb.push_back({1'b0, 8'h33}); sb.push_back({1'b1, 8'h44});
        do_start(10'd0, 10'd4);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_mem_a", 32'(mem_a), 32'd0);
        chk("t1_valid_t1", 32'(m_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_valid_t2", 32'(m_valid), 32'd1);
        wait_done("t1_done_time", 5);
`ifdef SEG_STREAM_CHECKSUM_EN
        exp_csum = 16'h00AA;
`else
        exp_csum = 16'h0000;
`endif
        chk("t1_checksum", 32'(checksum), 32'(exp_csum));
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Address wrap 98,99,0,1
        mem[98] = 8'hA0; mem[99] = 8'hA1; mem[0] = 8'hB0; mem[1] = 8'hB1;
        sb.push_back({1'b0, 8'hA0}); sb.push_back({1'b0, 8'hA1});
        sb.push_back({1'b0, 8'hB0}); sb.push_back({1'b1, 8'hB1});
        do_start(10'd98, 10'd4);
        chk("t2_mem_a0", 32'(mem_a), 32'd98);
        @(posedge clk); #1;
        chk("t2_mem_a1", 32'(mem_a), 32'd99);
        @(posedge clk); #1;
        chk("t2_mem_a2", 32'(mem_a), 32'd0);
        @(posedge clk); #1;
        chk("t2_mem_a3", 32'(mem_a), 32'd1);
        wait_done("t2_done_time", 5);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: 3 stall cycles after the first valid beat
        mem[10] = 8'h05; mem[11] = 8'h06; mem[12] = 8'h07;
        sb.push_back({1'b0, 8'h05}); sb.push_back({1'b0, 8'h06}); sb.push_back({1'b1, 8'h07});
        do_start(10'd10, 10'd3);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        hold_d = m_data;
        hold_a = mem_a;
        chk("t3_first_data", 32'(hold_d), 32'h05);
        chk("t3_first_addr", 32'(hold_a), 32'd11);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("t3_hold_data", 32'(m_data), 32'(hold_d));
            chk("t3_hold_addr", 32'(mem_a), 32'(hold_a));
            chk("t3_hold_valid", 32'(m_valid), 32'd1);
        end
        m_ready = 1'b1;
        wait_done("t3_done_time", 7);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Zero-length command
        do_start(10'd5, 10'd0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_valid", 32'(m_valid), 32'd0);
        @(posedge clk); #1;
        chk("t4_done_clear", 32'(done), 32'd0);

        // Reset after two of five beats accepted
        for (int i = 0; i < 5; i++) mem[i] = 8'(8'h60 + i);
        sb.push_back({1'b0, 8'h60}); sb.push_back({1'b0, 8'h61});
        do_start(10'd0, 10'd5);
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_data", 32'(m_data), 32'd0);
        chk("t5_rst_last", 32'(m_last), 32'd0);
        chk("t5_rst_mem_a", 32'(mem_a), 32'd0);
        chk("t5_rst_checksum", 32'(checksum), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_no_done", 32'(done), 32'd0);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        sb.push_back({1'b1, 8'h60});
        do_start(10'd0, 10'd1);
        wait_done("t5_restart_done_time", 2);
        chk("t5_restart_sb_empty", 32'(sb.size()), 32'd0);

        // start during RUN is ignored
        mem[20] = 8'hC0; mem[21] = 8'hC1; mem[22] = 8'hC2;
        sb.push_back({1'b0, 8'hC0}); sb.push_back({1'b0, 8'hC1}); sb.push_back({1'b1, 8'hC2});
        do_start(10'd20, 10'd3);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 10'd50; length = 10'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t6_done_time", 4);
        chk("t6_mem_a_hold", 32'(mem_a), 32'd23);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_idle_valid", 32'(m_valid), 32'd0);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_stream_reader.md
Name: seg_stream_reader

Overview:
- Initiator on the read side of one data segment of the segmented memory, e.g. the 8-bit result segment.
- On a start command it walks a contiguous address range of that segment.
- It registers each returned word and presents it on a valid/ready stream with a last flag.
- Typical use: streaming algorithm results out to a debug/UART path after the core finishes.
- The segment read port is combinational (rd follows a in the same cycle); this block owns the address.

Parameters:
DATA_W, 8, width of one segment word and of the stream data
ADDR_W, 10, width of the segment address
DEPTH, 100, number of valid words in the segment; address wraps DEPTH-1 -> 0
LEN_W, 10, width of the length field

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle command strobe, sampled only in IDLE
base_addr  in  ADDR_W  first word address; must be < DEPTH
length  in  LEN_W  number of words to stream
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the last beat is accepted
mem_a  out  ADDR_W  segment read address
mem_rd  in  DATA_W  segment read data, combinational from mem_a
m_valid  out  1  stream data valid
m_data  out  DATA_W  stream data
m_last  out  1  marks the final beat
m_ready  in  1  downstream accept
checksum  out  16  running sum of streamed words (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, m_valid, m_last=0; m_data, mem_a, checksum=0.

- States and transitions:
  - IDLE: on start with length!=0, latch addr=base_addr, remaining=length, clear checksum, go to RUN.
  - IDLE: on start with length==0, go to DONE; no beats are emitted.
  - RUN: stream beats (rules below). When a beat with m_last is accepted (m_valid&m_ready&m_last), go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.

- Command handling:
  - start is ignored in RUN and DONE.
  - base_addr and length are sampled only on the start cycle.

- Fetch rule in RUN:
  - fetch = (remaining!=0) && (!m_valid || m_ready).
  - On fetch: m_data<=mem_rd, m_valid<=1, m_last<=(remaining==1), remaining<=remaining-1, addr<=(addr==DEPTH-1)?0:addr+1.
  - If m_valid&&m_ready and no fetch, m_valid<=0 and m_last<=0.

- mem_a = addr, registered. It holds its last value in IDLE/DONE.

- Latency: start at cycle T -> busy=1 and mem_a=base_addr at T+1 -> first beat valid at T+2.

- Throughput: one beat per cycle while m_ready=1. Total for L words with m_ready held high: done at T+L+2.

- Backpressure: while m_valid&&!m_ready, m_data, m_last and mem_a are held stable; no fetch occurs.

- Reset mid-stream: everything returns to reset values immediately; no done pulse is produced.

- length larger than DEPTH is legal: the address wraps and words repeat.

Optional Feature:
- Macro: SEG_STREAM_CHECKSUM_EN.
- Defined: checksum accumulates (mod 2^16) the zero-extended m_data of every accepted beat. It is cleared on an accepted start and holds its value from done until the next start.
- Undefined: the accumulator logic is absent and checksum is tied to 0.

Test Plan:
- Segment words 0..3 = 0x11,0x22,0x33,0x44; start base=0 len=4, m_ready=1 -> beats 0x11,0x22,0x33,0x44 on cycles T+2..T+5, m_last only on 0x44, done at T+6. With the macro, checksum=0x00AA.
- base=98 len=4, DEPTH=100, words 98,99,0,1 = 0xA0,0xA1,0xB0,0xB1 -> mem_a sequence 98,99,0,1; beats in that order.
- len=3, m_ready low for 3 cycles after the first valid -> m_data/mem_a held stable, no beat lost or duplicated, exactly 3 beats.
- start with len=0 -> no m_valid at all, done pulse at T+1, busy never high.
- Reset asserted after 2 of 5 beats -> all outputs 0 next edge, no done. A new start base=0 len=1 then streams word 0 normally.
- Pulse start again during RUN with different base -> ignored; the original beat count and addresses complete unchanged.
